dht_sensor_controller: RTL

Parametrised single-wire controller for DHT11/DHT22 humidity/temperature sensors. It generates the host start pulse, detects the sensor acknowledge, and times each of the 40 data bits. It then verifies the checksum and presents formatted humidity and temperature words with done, valid and error status. The block sits between the sensor top-level glue (start request, display/UART consumers) and the bidirectional `dhtio` pad.

---
 rtl/dht_pkg.sv | 48 ++++
 rtl/tick_gen_us.sv | 36 +++
 rtl/dht_sensor_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 single-wire controller.
// Contents:
//   state_t      - controller FSM states (also driven out on the debug port)
//   err_t        - error codes reported on the error port
//   FRAME_BITS   - data bits per sensor frame
//   BYTE_BITS    - bits per frame byte
//   csum_ok      - frame checksum test
//   dht22_temp   - DHT22 sign-magnitude to two's-complement conversion
package dht_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_ACK_L     = 4'd3,
    ST_ACK_H     = 4'd4,
    ST_BIT_L     = 4'd5,
    ST_BIT_H     = 4'd6,
    ST_CHECK     = 4'd7,
    ST_ERR       = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_NOACK = 2'b01,
    ERR_BIT   = 2'b10,
    ERR_CSUM  = 2'b11
  } err_t;

  localparam int FRAME_BITS = 40;
  localparam int BYTE_BITS  = 8;

  // Frame layout, MSB first: b0 b1 b2 b3 b4, b4 is the checksum byte.
  // The 8-bit sum wraps, giving the mod-256 checksum directly.
  function automatic logic csum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [BYTE_BITS-1:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

  // Bit 15 is the sign, bits 14:0 the magnitude.
  function automatic logic [15:0] dht22_temp(input logic [15:0] raw);
    logic [15:0] mag;
    mag = {1'b0, raw[14:0]};
    return raw[15] ? (16'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/tick_gen_us.sv
// Free-running 1 us tick generator.
// Parameters:
//   CLK_FREQ_HZ - system clock frequency; divider is CLK_FREQ_HZ/1_000_000
// Ports:
//   clk  in  - system clock
//   rst  in  - asynchronous active-high reset
//   tick out - single-cycle pulse once per microsecond
module tick_gen_us #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values and simulation order between blocks cannot matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht_sensor_controller.sv
// DHT11/DHT22 single-wire controller: issues the host start pulse, detects
// the sensor acknowledge, times the 40 data bits, verifies the checksum and
// presents formatted humidity/temperature with done/valid/error status.
// Parameters:
//   CLK_FREQ_HZ, START_LOW_US, BIT_THRESH_US, TIMEOUT_US, SYNC_STAGES (>=2)
// Ports:
//   clk, rst      in  - clock, asynchronous active-high reset
//   start         in  - transaction request, sampled only in IDLE
//   sensor_type   in  - 0 = DHT11, 1 = DHT22, latched on start
//   humidity      out - last good humidity word
//   temperature   out - last good temperature word
//   done          out - one-cycle pulse at the end of every transaction
//   valid         out - 1 when the most recent transaction passed
//   error         out - err_t code of the most recent transaction
//   busy          out - high in every state except IDLE
//   debug         out - current state encoding
//   dhtio         io  - open-drain sensor line (drives 0 or Z only)
module dht_sensor_controller
  import dht_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 19000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sensor_type,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        done,
  output logic        valid,
  output logic [1:0]  error,
  output logic        busy,
  output logic [3:0]  debug,
  inout  wire         dhtio
);

  localparam int MAX_A  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int MAX_US = (MAX_A > BIT_THRESH_US) ? MAX_A : BIT_THRESH_US;
  localparam int CNT_W  = $clog2(MAX_US + 2);

  localparam logic [CNT_W-1:0] START_CNT   = CNT_W'(START_LOW_US);
  localparam logic [CNT_W-1:0] THRESH_CNT  = CNT_W'(BIT_THRESH_US);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_US);
  localparam logic [5:0]       LAST_BIT    = 6'(FRAME_BITS - 1);

  state_t                  state, state_next;
  err_t                    err_pend, err_next;
  logic                    tick;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    line;
  logic [CNT_W-1:0]        us_cnt;
  logic                    timed_out;
  logic                    shift_bit;
  logic [FRAME_BITS-1:0]   shreg;
  logic [5:0]              bit_cnt;
  logic                    type_q;

  tick_gen_us #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Only the host start pulse pulls the line; the pull-up supplies high.
  // Decoding from the state register makes the release asynchronous on rst.
  assign dhtio = (state == ST_START_LOW) ? 1'b0 : 1'bz;

  // The idle bus is high, so the synchronizer resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], dhtio};
  end
  assign line = sync_q[SYNC_STAGES-1];

  assign timed_out = (us_cnt >= TIMEOUT_CNT);
  assign busy      = (state != ST_IDLE);
  assign debug     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    err_next   = ERR_NOACK;
    shift_bit  = 1'b0;
    unique case (state)
      ST_IDLE:      if (start) state_next = ST_START_LOW;
      ST_START_LOW: if (tick && us_cnt == START_CNT) state_next = ST_RELEASE;
      ST_RELEASE: if (tick) begin
        if (!line)          state_next = ST_ACK_L;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_ACK_L: if (tick) begin
        if (line)           state_next = ST_ACK_H;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_ACK_H: if (tick) begin
        if (!line)          state_next = ST_BIT_L;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_BIT_L: begin
        err_next = ERR_BIT;
        if (tick) begin
          if (line)           state_next = ST_BIT_H;
          else if (timed_out) state_next = ST_ERR;
        end
      end
      ST_BIT_H: begin
        err_next = ERR_BIT;
        // The falling edge is tested before the timeout, so an edge on the
        // same tick as the timeout still completes the bit.
        if (tick) begin
          if (!line) begin
            shift_bit  = 1'b1;
            state_next = (bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_L;
          end else if (timed_out) begin
            state_next = ST_ERR;
          end
        end
      end
      ST_CHECK: state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Shared microsecond counter: cleared on every transition, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         us_cnt <= '0;
    else if (state_next != state)    us_cnt <= '0;
    else if (tick && us_cnt != '1)   us_cnt <= us_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      type_q   <= 1'b0;
      err_pend <= ERR_NONE;
    end else begin
      if (state == ST_IDLE && start) begin
        shreg   <= '0;
        bit_cnt <= '0;
        type_q  <= sensor_type;
      end else if (shift_bit) begin
        shreg   <= {shreg[FRAME_BITS-2:0], (us_cnt > THRESH_CNT)};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state_next == ST_ERR && state != ST_ERR) err_pend <= err_next;
    end
  end

  // Results update together on the edge that leaves CHECK or ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      humidity    <= '0;
      temperature <= '0;
      valid       <= 1'b0;
      error       <= ERR_NONE;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_CHECK) begin
        done <= 1'b1;
        if (csum_ok(shreg)) begin
          valid       <= 1'b1;
          error       <= ERR_NONE;
          humidity    <= shreg[39:24];
          temperature <= type_q ? dht22_temp(shreg[23:8]) : shreg[23:8];
        end else begin
          valid <= 1'b0;
          error <= ERR_CSUM;
        end
      end else if (state == ST_ERR) begin
        done  <= 1'b1;
        valid <= 1'b0;
        error <= err_pend;
      end
    end
  end

endmodule
